// File: rtl/mul_8bits_seq.sv
// Sequential 8x8 unsigned shift-and-add multiplier with a start/busy/done handshake.
// One partial-product addition per cycle through a single adder_8bits instance.

module adder_8bits (
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       cin_i,
  output logic [7:0] sum_o,
  output logic       cout_o
);
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {8'h00, cin_i};
endmodule

// Handshake: start is sampled only in IDLE, together with A/B. busy is high for the
// eight RUN cycles; done pulses for one cycle when P is updated. Never both high.
module mul_8bits_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] P,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q;
  logic [7:0]  m_q;
  logic [7:0]  acc_q;
  logic [7:0]  q_q;
  logic [2:0]  cnt_q;
  logic [15:0] p_q;
  logic        busy_q;
  logic        done_q;

  logic [7:0]  addend;
  logic [7:0]  sum;
  logic        carry;
  logic [7:0]  acc_d;
  logic [7:0]  q_d;

  assign addend = q_q[0] ? m_q : 8'h00;

  adder_8bits u_add (
    .a_i    (acc_q),
    .b_i    (addend),
    .cin_i  (1'b0),
    .sum_o  (sum),
    .cout_o (carry)
  );

  // The carry is the 9th bit of the partial sum and shifts into ACC[7].
  assign acc_d = {carry, sum[7:1]};
  assign q_d   = {sum[0], q_q[7:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= 8'h00;
      acc_q   <= 8'h00;
      q_q     <= 8'h00;
      cnt_q   <= 3'd0;
      p_q     <= 16'h0000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            m_q     <= A;
            acc_q   <= 8'h00;
            q_q     <= B;
            cnt_q   <= 3'd0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            p_q     <= {acc_d, q_d};
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign P    = p_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mul_8bits_seq.sv
// Bench for mul_8bits_seq: directed and random operations checked against an
// arithmetic product model, with handshake timing, ignored starts, reset abort and streaming.

module tb_mul_8bits_seq;
  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] P;
  logic        busy;
  logic        done;

  logic [15:0] exp_q[$];
  int          n_cmp;
  int          n_err;

  mul_8bits_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .P     (P),
    .busy  (busy),
    .done  (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // One operation: drive start for one cycle, optionally re-pulse start (with FF/FF)
  // at negedge poke_k while busy, then observe 11 cycles of outputs.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input int poke_k);
    int busy_cycles;
    int done_at;
    int done_cnt;
    int overlap;
    @(negedge clk);
    start = 1'b1; A = a; B = b;
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b0; A = 8'($urandom); B = 8'($urandom);
    busy_cycles = 0; done_at = 0; done_cnt = 0; overlap = 0;
    for (int k = 1; k <= 11; k++) begin
      if (busy) busy_cycles++;
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = k;
      end
      if (busy && done) overlap++;
      if (k == poke_k) begin
        start = 1'b1; A = 8'hFF; B = 8'hFF;
      end else begin
        start = 1'b0; A = 8'($urandom); B = 8'($urandom);
      end
      if (k != 11) @(negedge clk);
    end
    chk({tag, " busy_cycles"}, 16'(busy_cycles), 16'd8);
    chk({tag, " done_at"}, 16'(done_at), 16'd9);
    chk({tag, " done_cnt"}, 16'(done_cnt), 16'd1);
    chk({tag, " overlap"}, 16'(overlap), 16'd0);
    chk({tag, " P"}, P, exp_q.pop_front());
  endtask

  initial begin
    int done_t[$];
    int done_seen;
    int busy_seen;
    logic [7:0] ra;
    logic [7:0] rb;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset P", P, 16'h0000);
    chk("reset busy", {15'b0, busy}, 16'h0000);
    chk("reset done", {15'b0, done}, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    // directed
    run_op("0Fx0F", 8'h0F, 8'h0F, 16'h00E1, 0);
    run_op("FFxFF", 8'hFF, 8'hFF, 16'hFE01, 0);
    run_op("80x02", 8'h80, 8'h02, 16'h0100, 0);
    run_op("00x5A", 8'h00, 8'h5A, 16'h0000, 0);
    run_op("01xFF", 8'h01, 8'hFF, 16'h00FF, 0);
    run_op("12x34 ignored start", 8'h12, 8'h34, 16'h03A8, 4);

    // reset abort mid-operation
    @(negedge clk);
    start = 1'b1; A = 8'hC3; B = 8'h7E;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort P", P, 16'h0000);
    chk("abort busy", {15'b0, busy}, 16'h0000);
    chk("abort done", {15'b0, done}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0; busy_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) done_seen++;
      if (busy) busy_seen++;
    end
    chk("abort no done", 16'(done_seen), 16'd0);
    chk("abort no busy", 16'(busy_seen), 16'd0);
    run_op("05x07 after abort", 8'h05, 8'h07, 16'h0023, 0);

    // random operations, some with ignored start pulses during RUN/DONE
    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      if (i % 4 == 0) ra = 8'($urandom_range(0, 3));
      run_op($sformatf("rand%0d", i), ra, rb, 16'(ra) * 16'(rb), int'($urandom_range(0, 9)));
    end

    // start held high: operations accepted every 10 cycles, A/B change every cycle
    for (int t = 0; t <= 31; t++) begin
      @(negedge clk);
      if (done) begin
        done_t.push_back(t);
        chk($sformatf("stream P t=%0d", t), P, exp_q.pop_front());
      end
      start = (t <= 20);
      A = 8'($urandom);
      B = 8'($urandom);
      if (t % 10 == 0 && t <= 20) exp_q.push_back(16'(A) * 16'(B));
    end
    start = 1'b0;
    chk("stream done count", 16'(done_t.size()), 16'd3);
    if (done_t.size() == 3) begin
      chk("stream first done", 16'(done_t[0]), 16'd9);
      chk("stream spacing 1", 16'(done_t[1] - done_t[0]), 16'd10);
      chk("stream spacing 2", 16'(done_t[2] - done_t[1]), 16'd10);
    end
    chk("model queue drained", 16'(exp_q.size()), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_8bits_seq.md
Name: mul_8bits_seq

Overview:
- Sequential 8x8 unsigned shift-and-add multiplier sitting directly downstream of the team's 8-bit adder stage.
- Each cycle it consumes one 8-bit addition: it instantiates adder_8bits once for the partial-product add (accumulator + multiplicand) and registers the sum and carry.
- It produces a 16-bit product after a fixed 8-iteration sequence, using a start/busy/done handshake.

Parameters:
- None. Width is fixed at 8 bits per operand and 16 bits for the product.

Ports:
- clk    input   1   rising-edge clock
- rst    input   1   asynchronous, active-high reset
- start  input   1   request; sampled only in IDLE
- A      input   8   multiplicand, unsigned; sampled with start
- B      input   8   multiplier, unsigned; sampled with start
- P      output  16  product register
- busy   output  1   high while iterating (RUN)
- done   output  1   one-cycle pulse when P is updated

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE; P=16'h0000, busy=0, done=0.
  - Internal M, ACC, Q and the iteration counter are all cleared.
  - Reset asserted mid-operation aborts the operation immediately; P is cleared and no done pulse occurs.
- State IDLE:
  - On a clk edge with start=1: M<=A, ACC<=0, Q<=B, cnt<=0, go to RUN.
  - With start=0: stay in IDLE.
- State RUN (busy=1), one iteration per clk edge:
  - Adder inputs: A=ACC, B=(Q[0] ? M : 8'h00), Cin=0, giving sum[7:0] and carry C.
  - Register update: {ACC,Q} <= {C, sum, Q} >> 1. In other words, ACC<={C,sum[7:1]} and Q<={sum[0],Q[7:1]}.
  - cnt increments on each RUN edge.
  - On the edge where cnt==7 (the 8th iteration):
    - go to DONE;
    - on the same edge, P<={ACC_next, Q_next} (the final shifted values).
- State DONE:
  - done=1 and busy=0 for exactly one cycle.
  - Unconditionally return to IDLE on the next edge.
- Timing:
  - Start accepted at edge E0; iterations occur on edges E1..E8; P valid and done=1 in the cycle following E8.
  - Total latency is 8 cycles from start acceptance to P valid, and one operation completes per 10 cycles.
  - The earliest next start is accepted at E10, in IDLE.
- Outputs:
  - busy and done are registered and are never high simultaneously.
  - P holds its value until the next completion or reset.
- start handling:
  - start while in RUN or DONE is ignored. It is not queued, and A/B changes during RUN do not affect the result.
  - start held high continuously yields back-to-back operations, each re-sampling A/B in IDLE.
- Arithmetic:
  - The result is exact unsigned A*B with no overflow, since P is 16 bits.
  - The adder carry C must be kept on every iteration; it is the 9th bit of the partial sum.
- Boundary cases:
  - A=0 or B=0 gives P=0 and still takes the full 8 iterations.
  - Q[0]=0 iterations shift only.
- Encoding: no X propagation out of reset; unused state encodings return to IDLE.

Test Plan:
- Reset then start with A=8'h0F, B=8'h0F:
  - busy high for exactly 8 cycles;
  - done pulses once in the 9th cycle after the start edge;
  - P=16'h00E1.
- A=8'hFF, B=8'hFF (exercises carry on every add) -> P=16'hFE01. Also check A=8'h80, B=8'h02 -> P=16'h0100.
- A=8'h00, B=8'h5A -> P=16'h0000 with done after the full latency. Also check A=8'h01, B=8'hFF -> P=16'h00FF.
- Start A=8'h12, B=8'h34, then during RUN pulse start with A=8'hFF, B=8'hFF:
  - the second start is ignored;
  - P=16'h03A8;
  - only one done pulse occurs.
- Start A=8'hC3, B=8'h7E and assert rst at iteration 4:
  - P=0, busy=0, done=0 immediately;
  - after release and a new start with A=8'h05, B=8'h07 -> P=16'h0023.
- start held high for 3 operations with A/B changed each IDLE cycle:
  - done pulses are spaced 10 cycles apart;
  - each P matches the A*B sampled for that operation.
